alu_operand_stage: RTL and testbench

//  ID/EX operand register stage directly upstream of the ALU (add/sub/and/or/slt32).

---
 rtl/alu_operand_stage.sv | 89 ++++++++
 tb/tb_alu_operand_stage.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
// ID/EX operand register stage feeding the ALU: resolves forwarding and the
// immediate select, then holds A, B and the ALU control behind a valid/ready handshake.
module alu_operand_stage #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 3,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  rs_data,
    input  logic [WIDTH-1:0]  rt_data,
    input  logic [WIDTH-1:0]  imm32,
    input  logic              alu_src_b,
    input  logic [1:0]        fwd_a,
    input  logic [1:0]        fwd_b,
    input  logic [WIDTH-1:0]  exmem_res,
    input  logic [WIDTH-1:0]  memwb_res,
    input  logic [CTRL_W-1:0] alu_ctrl_i,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [WIDTH-1:0]  A,
    output logic [WIDTH-1:0]  B,
    output logic [CTRL_W-1:0] alu_ctrl_o,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  stall_cnt
);

    // Handshake: a transfer into the stage happens on an edge where
    // in_valid && in_ready && !flush; a transfer out happens where out_valid && out_ready.
    logic [WIDTH-1:0] mux_a;
    logic [WIDTH-1:0] rt_fwd;
    logic [WIDTH-1:0] mux_b;
    logic             accept;
    logic             stalled;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign stalled  = out_valid && !out_ready && !flush;

    always_comb begin
        mux_a = rs_data;
        case (fwd_a)
            2'b01:   mux_a = exmem_res;
            2'b10:   mux_a = memwb_res;
            default: mux_a = rs_data;
        endcase
    end

    always_comb begin
        rt_fwd = rt_data;
        case (fwd_b)
            2'b01:   rt_fwd = exmem_res;
            2'b10:   rt_fwd = memwb_res;
            default: rt_fwd = rt_data;
        endcase
    end

    // The immediate bypasses forwarding: it is never a hazard source.
    assign mux_b = alu_src_b ? imm32 : rt_fwd;

    always_ff @(posedge clk) begin
        if (rst) begin
            A          <= '0;
            B          <= '0;
            alu_ctrl_o <= '0;
            out_valid  <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (accept) begin
            A          <= mux_a;
            B          <= mux_b;
            alu_ctrl_o <= alu_ctrl_i;
            out_valid  <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stalled && (stall_cnt != {CNT_W{1'b1}})) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage: directed scenarios then random traffic,
// with a second instance at CNT_W=2 to exercise stall counter saturation.
module tb_alu_operand_stage;

    localparam int W = 32;
    localparam int C = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [W-1:0]  rs_data = '0, rt_data = '0, imm32 = '0, exmem_res = '0, memwb_res = '0;
    logic          alu_src_b = 1'b0;
    logic [1:0]    fwd_a = '0, fwd_b = '0;
    logic [C-1:0]  alu_ctrl_i = '0;
    logic          in_valid = 1'b0, flush = 1'b0, out_ready = 1'b0;

    logic          in_ready, out_valid;
    logic [W-1:0]  A, B;
    logic [C-1:0]  alu_ctrl_o;
    logic [15:0]   stall_cnt;

    logic          in_ready2, out_valid2;
    logic [W-1:0]  a2, b2;
    logic [C-1:0]  ctrl2;
    logic [1:0]    stall_cnt2;

    alu_operand_stage #(.WIDTH(W), .CTRL_W(C), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rs_data(rs_data), .rt_data(rt_data), .imm32(imm32),
        .alu_src_b(alu_src_b), .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_res(exmem_res),
        .memwb_res(memwb_res), .alu_ctrl_i(alu_ctrl_i), .in_valid(in_valid),
        .in_ready(in_ready), .flush(flush), .A(A), .B(B), .alu_ctrl_o(alu_ctrl_o),
        .out_valid(out_valid), .out_ready(out_ready), .stall_cnt(stall_cnt)
    );

    alu_operand_stage #(.WIDTH(W), .CTRL_W(C), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .rs_data(rs_data), .rt_data(rt_data), .imm32(imm32),
        .alu_src_b(alu_src_b), .fwd_a(fwd_a), .fwd_b(fwd_b), .exmem_res(exmem_res),
        .memwb_res(memwb_res), .alu_ctrl_i(alu_ctrl_i), .in_valid(in_valid),
        .in_ready(in_ready2), .flush(flush), .A(a2), .B(b2), .alu_ctrl_o(ctrl2),
        .out_valid(out_valid2), .out_ready(out_ready), .stall_cnt(stall_cnt2)
    );

    // Clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: stage occupancy, last loaded operands, stall counters.
    logic [W+W+C-1:0] exp_q[$];
    bit               m_valid = 0;
    logic [W-1:0]     last_a = '0, last_b = '0;
    logic [C-1:0]     last_c = '0;
    int unsigned      cnt16 = 0, cnt2 = 0;

    function automatic logic [W-1:0] pick(input logic [1:0] sel, input logic [W-1:0] reg_val);
        if (sel == 2'd1) return exmem_res;
        if (sel == 2'd2) return memwb_res;
        return reg_val;
    endfunction

    always @(posedge clk) begin
        bit ready;
        logic [W-1:0] ea, eb;
        if (rst) begin
            m_valid = 0;
            exp_q.delete();
            last_a = '0; last_b = '0; last_c = '0;
            cnt16 = 0; cnt2 = 0;
        end else begin
            ready = !m_valid || out_ready;
            if (flush) begin
                if (m_valid && exp_q.size() > 0) void'(exp_q.pop_back());
                m_valid = 0;
            end else begin
                if (m_valid && !out_ready) begin
                    if (cnt16 < 65535) cnt16++;
                    if (cnt2 < 3) cnt2++;
                end
                if (in_valid && ready) begin
                    ea = pick(fwd_a, rs_data);
                    eb = alu_src_b ? imm32 : pick(fwd_b, rt_data);
                    exp_q.push_back({ea, eb, alu_ctrl_i});
                    last_a = ea; last_b = eb; last_c = alu_ctrl_i;
                    m_valid = 1;
                end else if (m_valid && out_ready) begin
                    m_valid = 0;
                end
            end
        end
    end

    // Monitor: checks presented state each cycle, pops the scoreboard on each consume.
    always @(negedge clk) begin
        logic [W+W+C-1:0] e;
        chk("out_valid", out_valid, m_valid);
        chk("in_ready", in_ready, !m_valid || out_ready);
        chk("held_A", A, last_a);
        chk("held_B", B, last_b);
        chk("held_ctrl", alu_ctrl_o, last_c);
        chk("stall_cnt", stall_cnt, cnt16);
        chk("stall_cnt_sat", stall_cnt2, cnt2);
        chk("sat_inst_state", {out_valid2, in_ready2, a2, b2, ctrl2},
            {m_valid, !m_valid || out_ready, last_a, last_b, last_c});
        if (out_valid && out_ready && !flush && !rst) begin
            if (exp_q.size() == 0) begin
                chk("consume_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                chk("consume_txn", {A, B, alu_ctrl_o}, e);
            end
        end
    end

    // Driver
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic [W-1:0] rs, input logic [W-1:0] rt,
                          input logic [1:0] fa, input logic [1:0] fb,
                          input logic src, input logic [C-1:0] ctrl);
        rs_data = rs; rt_data = rt; fwd_a = fa; fwd_b = fb;
        alu_src_b = src; alu_ctrl_i = ctrl;
    endtask

    initial begin
        rst = 1'b1;
        repeat (2) step();
        chk("rst_A", A, 0);
        chk("rst_B", B, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_stall_cnt", stall_cnt, 0);
        rst = 1'b0;

        // Plain register-file operands
        set_in(32'd5, 32'd9, 2'b00, 2'b00, 1'b0, 3'b111);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        chk("t2_A", A, 5);
        chk("t2_B", B, 9);
        chk("t2_ctrl", alu_ctrl_o, 7);
        chk("t2_valid", out_valid, 1);

        // Forwarding paths and immediate select
        exmem_res = 32'hFFFF_FFFF; memwb_res = 32'h10; imm32 = 32'h20;
        set_in(32'h1, 32'h2, 2'b01, 2'b10, 1'b0, 3'b010);
        step();
        chk("t3_fwd_A", A, 32'hFFFF_FFFF);
        chk("t3_fwd_B", B, 32'h10);
        alu_src_b = 1'b1;
        step();
        chk("t3_imm_B", B, 32'h20);
        set_in(32'h1234, 32'h2, 2'b11, 2'b11, 1'b0, 3'b001);
        step();
        chk("t3_fwd11_A", A, 32'h1234);
        chk("t3_fwd11_B", B, 32'h2);
        in_valid = 1'b0;
        step();

        // Hold for 4 cycles
        set_in(32'hAA, 32'h1, 2'b00, 2'b00, 1'b0, 3'b000);
        in_valid = 1'b1; out_ready = 1'b0;
        step();
        rs_data = 32'hBB;
        repeat (4) step();
        chk("t4_hold_A", A, 32'hAA);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_stall_cnt", stall_cnt, 4);
        out_ready = 1'b1;
        step();
        chk("t4_new_A", A, 32'hBB);
        in_valid = 1'b0;
        step();

        // Flush while holding
        rs_data = 32'hCC; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        step();
        flush = 1'b1; in_valid = 1'b1; rs_data = 32'hDD;
        step();
        flush = 1'b0; in_valid = 1'b0;
        chk("t5_valid", out_valid, 0);
        chk("t5_A", A, 32'hCC);
        chk("t5_stall_cnt", stall_cnt, 5);

        // Back-to-back throughput
        out_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rs_data = 32'(100 + i);
            step();
            chk("t6_b2b_valid", out_valid, 1);
            chk("t6_b2b_A", A, 100 + i);
        end
        in_valid = 1'b0;
        step();

        // Saturation of the narrow counter
        rst = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        step();
        in_valid = 1'b0;
        repeat (6) step();
        chk("t6_sat_cnt2", stall_cnt2, 3);
        chk("t6_cnt16", stall_cnt, 6);
        out_ready = 1'b1;
        step();

        // Random traffic
        for (int n = 0; n < 3000; n++) begin
            rs_data   = $urandom; rt_data = $urandom; imm32 = $urandom;
            exmem_res = $urandom; memwb_res = $urandom;
            fwd_a     = 2'($urandom_range(0, 3));
            fwd_b     = 2'($urandom_range(0, 3));
            alu_src_b = 1'($urandom_range(0, 1));
            alu_ctrl_i = 3'($urandom_range(0, 7));
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 11) == 0);
            rst       = ($urandom_range(0, 199) == 0);
            step();
        end

        rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) step();
        chk("drain_queue_empty", 64'(exp_q.size()), 0);
        chk("drain_valid", out_valid, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
